// File: rtl/switch_event_arbiter.sv
// rtl/switch_event_arbiter.sv - debounced switch level changes to a round-robin press/release event stream
module switch_event_arbiter #(
    parameter int NUM_SWITCHES = 4,
    parameter int IDX_W        = 2
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_n,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    input  logic                    i_Event_Ready,
    input  logic                    i_Clear_Overflow,
    output logic                    o_Event_Valid,
    output logic [IDX_W-1:0]        o_Event_Idx,
    output logic                    o_Event_Press,
    output logic [NUM_SWITCHES-1:0] o_Pending,
    output logic                    o_Overflow
);
    localparam logic SLOT_EMPTY = 1'b0;
    localparam logic SLOT_FULL  = 1'b1;

    logic                    r_State;
    logic [NUM_SWITCHES-1:0] r_Prev;
    logic [NUM_SWITCHES-1:0] r_Pend;
    logic [NUM_SWITCHES-1:0] r_Type;
    logic [IDX_W-1:0]        r_Last;

    logic [NUM_SWITCHES-1:0] sw_edge;
    logic [NUM_SWITCHES-1:0] load_mask;
    logic                    handshake;
    logic                    load;
    logic                    hi_found;
    logic                    lo_found;
    logic [IDX_W-1:0]        hi_idx;
    logic [IDX_W-1:0]        lo_idx;
    logic                    hi_type;
    logic                    lo_type;
    logic [IDX_W-1:0]        grant_idx;
    logic                    grant_type;
    logic                    ovf_set;

    assign sw_edge       = i_Switch ^ r_Prev;
    assign o_Event_Valid = (r_State == SLOT_FULL);
    assign o_Pending     = r_Pend;
    assign handshake     = o_Event_Valid && i_Event_Ready;
    assign load          = (!o_Event_Valid || handshake) && lo_found;

    // Round robin as two priority searches: lowest pending index above r_Last,
    // otherwise lowest pending index overall (the wrap-around case).
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_type  = 1'b0;
        lo_type  = 1'b0;
        for (int i = NUM_SWITCHES - 1; i >= 0; i--) begin
            if (r_Pend[i]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(i);
                lo_type  = r_Type[i];
                if (IDX_W'(i) > r_Last) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                    hi_type  = r_Type[i];
                end
            end
        end
    end

    assign grant_idx  = hi_found ? hi_idx  : lo_idx;
    assign grant_type = hi_found ? hi_type : lo_type;

    always_comb begin
        load_mask = '0;
        for (int i = 0; i < NUM_SWITCHES; i++) begin
            load_mask[i] = load && (grant_idx == IDX_W'(i));
        end
    end

    // A channel being loaded this cycle can take a fresh edge without losing anything.
    assign ovf_set = |(sw_edge & r_Pend & ~load_mask);

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State       <= SLOT_EMPTY;
            r_Prev        <= '0;
            r_Pend        <= '0;
            r_Type        <= '0;
            r_Last        <= IDX_W'(NUM_SWITCHES - 1);
            o_Event_Idx   <= '0;
            o_Event_Press <= 1'b0;
            o_Overflow    <= 1'b0;
        end else begin
            r_Prev <= i_Switch;
            r_Pend <= (r_Pend & ~load_mask) | sw_edge;
            r_Type <= (r_Type & ~sw_edge) | (i_Switch & sw_edge);

            if (load) begin
                r_State       <= SLOT_FULL;
                o_Event_Idx   <= grant_idx;
                o_Event_Press <= grant_type;
                r_Last        <= grant_idx;
            end else if (handshake) begin
                r_State <= SLOT_EMPTY;
            end

            if (ovf_set) begin
                o_Overflow <= 1'b1;
            end else if (i_Clear_Overflow) begin
                o_Overflow <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_switch_event_arbiter.sv
// tb/tb_switch_event_arbiter.sv - directed vector bench for switch_event_arbiter
module tb_switch_event_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       rdy;
    logic       clr;
    logic       ev_valid;
    logic [1:0] ev_idx;
    logic       ev_press;
    logic [3:0] pending;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] sw;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [1:0] idx;
        logic       p;
        logic [3:0] pend;
        logic       ovf;
    } vec_t;

    vec_t vecs[$];

    switch_event_arbiter #(
        .NUM_SWITCHES(4),
        .IDX_W       (2)
    ) dut (
        .i_Clk           (clk),
        .i_Rst_n         (rst_n),
        .i_Switch        (sw),
        .i_Event_Ready   (rdy),
        .i_Clear_Overflow(clr),
        .o_Event_Valid   (ev_valid),
        .o_Event_Idx     (ev_idx),
        .o_Event_Press   (ev_press),
        .o_Pending       (pending),
        .o_Overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] s, input logic r, input logic c, input logic v,
                       input logic [1:0] idx, input logic p, input logic [3:0] pend, input logic ovf);
        vec_t t;
        t.sw = s; t.rdy = r; t.clr = c; t.v = v; t.idx = idx; t.p = p; t.pend = pend; t.ovf = ovf;
        vecs.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [1:0] idx,
                             input logic p, input logic [3:0] pend, input logic ovf);
        check({tag, " valid"}, 32'(ev_valid), 32'(v));
        check({tag, " pending"}, 32'(pending), 32'(pend));
        check({tag, " overflow"}, 32'(overflow), 32'(ovf));
        if (v) begin
            check({tag, " idx"}, 32'(ev_idx), 32'(idx));
            check({tag, " press"}, 32'(ev_press), 32'(p));
        end
    endtask

    initial begin
        // Each row: inputs driven before an edge, outputs expected just after it.
        add(4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(4'b1111, 1, 0, 0, 0, 0, 4'b1111, 0);
        add(4'b1111, 1, 0, 1, 0, 1, 4'b1110, 0);
        add(4'b1111, 1, 0, 1, 1, 1, 4'b1100, 0);
        add(4'b1111, 1, 0, 1, 2, 1, 4'b1000, 0);
        add(4'b1111, 1, 0, 1, 3, 1, 4'b0000, 0);
        add(4'b0000, 1, 0, 0, 0, 0, 4'b1111, 0);
        add(4'b0000, 1, 0, 1, 0, 0, 4'b1110, 0);
        add(4'b0000, 1, 0, 1, 1, 0, 4'b1100, 0);
        add(4'b0000, 1, 0, 1, 2, 0, 4'b1000, 0);
        add(4'b0000, 1, 0, 1, 3, 0, 4'b0000, 0);
        add(4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(4'b0100, 1, 0, 0, 0, 0, 4'b0100, 0);
        add(4'b0100, 1, 0, 1, 2, 1, 4'b0000, 0);
        add(4'b0100, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(4'b0000, 1, 0, 0, 0, 0, 4'b0100, 0);
        add(4'b0000, 1, 0, 1, 2, 0, 4'b0000, 0);
        add(4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(4'b0010, 0, 0, 0, 0, 0, 4'b0010, 0);
        add(4'b1010, 0, 0, 1, 1, 1, 4'b1000, 0);
        for (int i = 0; i < 10; i++) add(4'b1010, 0, 0, 1, 1, 1, 4'b1000, 0);
        add(4'b1010, 1, 0, 1, 3, 1, 4'b0000, 0);
        add(4'b1010, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(4'b0000, 1, 0, 0, 0, 0, 4'b1010, 0);
        add(4'b0000, 1, 0, 1, 1, 0, 4'b1000, 0);
        add(4'b0000, 1, 0, 1, 3, 0, 4'b0000, 0);
        add(4'b0000, 1, 0, 0, 0, 0, 4'b0000, 0);
        add(4'b0001, 0, 0, 0, 0, 0, 4'b0001, 0);
        add(4'b0001, 0, 0, 1, 0, 1, 4'b0000, 0);
        add(4'b0011, 0, 0, 1, 0, 1, 4'b0010, 0);
        add(4'b0001, 0, 0, 1, 0, 1, 4'b0010, 1);
        add(4'b0001, 1, 0, 1, 1, 0, 4'b0000, 1);
        add(4'b0001, 1, 0, 0, 0, 0, 4'b0000, 1);
        add(4'b0001, 1, 1, 0, 0, 0, 4'b0000, 0);
        add(4'b0011, 0, 0, 0, 0, 0, 4'b0010, 0);
        add(4'b0011, 0, 0, 1, 1, 1, 4'b0000, 0);
        add(4'b0111, 0, 0, 1, 1, 1, 4'b0100, 0);
        add(4'b0011, 0, 1, 1, 1, 1, 4'b0100, 1);
        add(4'b0011, 0, 1, 1, 1, 1, 4'b0100, 0);
        add(4'b0111, 1, 0, 1, 2, 0, 4'b0100, 0);
        add(4'b0111, 1, 0, 1, 2, 1, 4'b0000, 0);
        add(4'b0111, 1, 0, 0, 0, 0, 4'b0000, 0);

        rst_n = 1'b0;
        sw    = 4'b0000;
        rdy   = 1'b1;
        clr   = 1'b0;
        #2;
        check_out("reset", 0, 0, 0, 4'b0000, 0);
        check("reset idx", 32'(ev_idx), 32'(0));
        check("reset press", 32'(ev_press), 32'(0));
        step();
        step();
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            sw  = vecs[i].sw;
            rdy = vecs[i].rdy;
            clr = vecs[i].clr;
            step();
            check_out($sformatf("row%0d", i), vecs[i].v, vecs[i].idx, vecs[i].p,
                      vecs[i].pend, vecs[i].ovf);
        end

        // Slot full with three channels pending and a sticky overflow, then async reset.
        clr = 1'b0;
        rdy = 1'b0;
        sw  = 4'b0000;
        step();
        check_out("mid a", 0, 0, 0, 4'b0111, 0);
        step();
        check_out("mid b", 1, 0, 0, 4'b0110, 0);
        sw = 4'b1000;
        step();
        check_out("mid c", 1, 0, 0, 4'b1110, 0);
        sw = 4'b1010;
        step();
        check_out("mid d", 1, 0, 0, 4'b1110, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async valid", 32'(ev_valid), 32'(0));
        check("async pending", 32'(pending), 32'(0));
        check("async overflow", 32'(overflow), 32'(0));
        check("async idx", 32'(ev_idx), 32'(0));
        rdy = 1'b1;
        step();
        check_out("held reset", 0, 0, 0, 4'b0000, 0);
        rst_n = 1'b1;
        step();
        check_out("post a", 0, 0, 0, 4'b1010, 0);
        step();
        check_out("post b", 1, 1, 1, 4'b1000, 0);
        step();
        check_out("post c", 1, 3, 1, 4'b0000, 0);
        step();
        check_out("post d", 0, 0, 0, 4'b0000, 0);
        step();
        check_out("post e", 0, 0, 0, 4'b0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/switch_event_arbiter.md
# switch_event_arbiter

Collects debounced switch levels from up to 16 debouncer instances and turns every level change into a press or release event. Events are delivered one at a time to a single consumer, such as a UI state machine or a UART reporter, over a valid/ready handshake. When several switches have events pending, a round-robin arbiter decides which one is delivered next. The block sits directly downstream of the per-switch debouncers and is the only path by which switch activity reaches the control logic.

## Interface
- NUM_SWITCHES, 4: number of debounced inputs; legal range 2..16.
- IDX_W, 2: width of the event index; 2^IDX_W must be >= NUM_SWITCHES.
- i_Clk  input  1: single clock; all logic is on the rising edge.
- i_Rst_n  input  1: reset, asynchronous, active-low; one clock domain.
- i_Switch  input  NUM_SWITCHES: debounced switch levels, already synchronous to i_Clk.
- i_Event_Ready  input  1: consumer accepts the current event on a cycle where o_Event_Valid && i_Event_Ready.
- i_Clear_Overflow  input  1: single-cycle pulse that clears o_Overflow.
- o_Event_Valid  output  1: an event is presented on o_Event_Idx / o_Event_Press.
- o_Event_Idx  output  IDX_W: channel number of the presented event.
- o_Event_Press  output  1: 1 = rising level (press), 0 = falling level (release).
- o_Pending  output  NUM_SWITCHES: per-channel pending flags, registered; for status and debug.
- o_Overflow  output  1: sticky; set when an undelivered event was overwritten.

## Operation
- **Edge detect.**
  - r_Prev[i] samples i_Switch[i] every clock.
  - An edge on channel i is i_Switch[i] != r_Prev[i]; its type is i_Switch[i].
- **Pending store.** Each channel has r_Pend[i] and r_Type[i].
  - An edge sets r_Pend[i] = 1 and r_Type[i] = the edge type.
  - Edge on a channel that is already pending and is not being loaded to the output this cycle:
    - r_Type[i] is overwritten with the newest edge type.
    - o_Overflow is set.
  - Edge on a channel that is being loaded to the output in the same cycle:
    - The old event goes to the output.
    - The new edge becomes pending.
    - No overflow.
- **Output slot.** The output is a single register with two states.
  - EMPTY: o_Event_Valid = 0.
  - FULL: o_Event_Valid = 1.
- **Load condition.** The slot loads when it is EMPTY, or when it is FULL and a handshake occurs this cycle, provided at least one r_Pend bit is set.
  - Loading clears the granted channel's r_Pend bit and copies its index and r_Type into the output.
  - Load condition true: the state becomes or stays FULL.
  - FULL with a handshake but nothing pending: the state goes to EMPTY.
- **Round robin.**
  - r_Last holds the last granted index.
  - The search order is r_Last+1, r_Last+2, …, wrapping from NUM_SWITCHES-1 to 0.
  - The first channel in that order with a pending flag is granted.
  - r_Last updates only on a load.
- **Overflow flag.**
  - o_Overflow stays set until i_Clear_Overflow.
  - If a clear and a new overflow occur in the same cycle, the set wins.
- **Channel mask.** Index values >= NUM_SWITCHES are never produced.

## Timing
- **Reset values** (asynchronous, while i_Rst_n = 0):
  - r_Prev = 0, r_Pend = 0, r_Type = 0, r_Last = NUM_SWITCHES-1.
  - Slot EMPTY: o_Event_Valid = 0, o_Event_Idx = 0, o_Event_Press = 0.
  - o_Pending = 0, o_Overflow = 0.
- **After reset release.** A switch already high produces a press event: r_Prev is 0 after reset, so the first clock sees an edge.
- **Latency.**
  - An i_Switch change sampled at edge k sets r_Pend at edge k.
  - With the slot EMPTY, o_Event_Valid is asserted after edge k+1.
  - This gives 2 cycles from the input change to the event being visible.
- **Throughput.** With i_Event_Ready held high, one event is delivered per cycle with no bubble.
- **Backpressure.**
  - While o_Event_Valid = 1 and i_Event_Ready = 0, o_Event_Idx and o_Event_Press hold stable.
  - Edges keep accumulating in r_Pend during backpressure.
- **Consumer rules.**
  - i_Event_Ready may be high while o_Event_Valid is low; this has no effect.
  - o_Event_Valid never drops without a handshake.
- **Reset mid-operation.**
  - All pending events and the in-flight event are discarded immediately, without waiting for a clock edge.
  - No partial event is visible after release.

## Test plan
- **Reset release, single press:**
  - Stimulus: NUM_SWITCHES = 4, i_Switch = 0000, ready = 1; set i_Switch[2] = 1 at edge k.
  - Response: Valid after edge k+1 for exactly one cycle with Idx = 2, Press = 1. Clearing i_Switch[2] later yields Idx = 2, Press = 0.
- **Simultaneous edges, fairness:**
  - Stimulus: i_Switch goes 0000 → 1111 in one cycle, ready = 1.
  - Response: four consecutive events with Idx 0, 1, 2, 3, all Press = 1. A following 1111 → 0000 transition yields 0, 1, 2, 3 again, since the pointer wraps from 3 to 0.
- **Backpressure hold:**
  - Stimulus: ready = 0; press ch1, then press ch3.
  - Response: Idx = 1 is held stable for 10 cycles; o_Pending = 1000. After raising ready, Idx = 1 then Idx = 3 are delivered on consecutive cycles.
- **Overflow:**
  - Stimulus: ready = 0 with ch0 occupying the slot; ch1 press then release while pending.
  - Response: o_Overflow = 1, and ch1 delivers a single event with Press = 0.
  - Then: pulse i_Clear_Overflow → o_Overflow = 0. A clear in the same cycle as a new overflow leaves o_Overflow = 1.
- **Same-cycle load and edge:**
  - Stimulus: ch2 pending and being loaded while ch2 toggles in the same cycle.
  - Response: the old event goes out, the new edge remains pending, and o_Overflow stays 0.
- **Reset mid-operation:**
  - Stimulus: assert i_Rst_n = 0 asynchronously with Valid = 1 and three channels pending.
  - Response: Valid, o_Pending and o_Overflow go low immediately, without a clock edge. After release, switches held high each produce exactly one press event.
